sysarr_wavefront_ctrl: RTL and testbench

SYSARR_WAVEFRONT_CTRL -- requirements
Module: sysarr_wavefront_ctrl

---
 rtl/sys_arr_pkg.sv | 18 +
 rtl/sysarr_wavefront_mask.sv | 26 ++
 rtl/sysarr_wavefront_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sysarr_wavefront_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// Shared types and default geometry for the systolic-array wavefront controller.
package sys_arr_pkg;

    localparam int unsigned DEF_ROWS  = 4;
    localparam int unsigned DEF_COLS  = 4;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        START,
        WAIT,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/sysarr_wavefront_mask.sv
// Diagonal wavefront mask: PE (r,c) is active at step k when 0 <= k-(r+c) < N.
module sysarr_wavefront_mask
    import sys_arr_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned KW   = 4,
    parameter int unsigned NW   = 4
) (
    input  logic [KW-1:0]        k_i,
    input  logic [NW-1:0]        n_i,
    output logic [ROWS*COLS-1:0] mask_o
);

    always_comb begin
        mask_o = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if ((32'(k_i) >= r + c) && (32'(k_i) - (r + c) < 32'(n_i))) begin
                    mask_o[r*COLS+c] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sysarr_wavefront_ctrl.sv
// Wavefront sequencer for a ROWS x COLS systolic array: load, step the diagonal, drain.
// Optional SYSARR_ZERO_SKIP_EN adds row_zero to suppress PE starts on all-zero rows.
module sysarr_wavefront_ctrl
    import sys_arr_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(DEPTH+1)-1:0] num_inputs,
    input  logic                       input_en,
    output logic                       fifo_has_space,
    output logic [ROWS*COLS-1:0]       pe_shift,
    output logic [ROWS*COLS-1:0]       pe_start,
    input  logic                       pe_value_ready,
    output logic [ROWS-1:0]            in_fifo_shift,
`ifdef SYSARR_ZERO_SKIP_EN
    input  logic [ROWS-1:0]            row_zero,
`endif
    input  logic [COLS-1:0]            acc_end_flags,
    input  logic [COLS-1:0]            add_value_ready,
    output logic [COLS-1:0]            add_start,
    output logic [COLS-1:0]            ps_fifo_shift,
    output logic                       busy,
    output logic                       drained,
    output logic                       done
);

    localparam int unsigned NW = $clog2(DEPTH + 1);
    localparam int unsigned KW = $clog2(DEPTH + ROWS + COLS);
    localparam int unsigned PE = ROWS * COLS;

    state_e            state_q, state_d;
    logic [NW-1:0]     n_q, n_d;
    logic [NW-1:0]     l_q, l_d;
    logic [KW-1:0]     k_q, k_d;
    logic [COLS-1:0]   col_done_q, col_done_d;
    logic [COLS-1:0]   add_start_q, add_start_d;
    logic [PE-1:0]     mask;
    logic [PE-1:0]     start_mask;
    logic [KW-1:0]     k_last;
    logic              skip_wait;

    sysarr_wavefront_mask #(
        .ROWS (ROWS),
        .COLS (COLS),
        .KW   (KW),
        .NW   (NW)
    ) u_mask (
        .k_i    (k_q),
        .n_i    (n_q),
        .mask_o (mask)
    );

    assign k_last = KW'(n_q) + KW'(ROWS + COLS - 3);

    // Rows flagged zero still pop their FIFO but their PEs are not started.
`ifdef SYSARR_ZERO_SKIP_EN
    logic [ROWS-1:0] row_active;
    always_comb begin
        start_mask = mask;
        row_active = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_active[r] = |mask[r*COLS +: COLS];
            if (row_zero[r]) begin
                start_mask[r*COLS +: COLS] = '0;
            end
        end
        skip_wait = ((row_active & ~row_zero) == '0);
    end
`else
    assign start_mask = mask;
    assign skip_wait  = 1'b0;
`endif

    // Next-state and datapath register update.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        l_d         = l_q;
        k_d         = k_q;
        col_done_d  = col_done_q | acc_end_flags;
        add_start_d = acc_end_flags;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d = (num_inputs > NW'(DEPTH)) ? NW'(DEPTH) : num_inputs;
                    l_d = '0;
                    k_d = '0;
                    if (n_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = LOAD;
                        col_done_d = '0;
                    end
                end
            end
            LOAD: begin
                if (l_q == n_q) begin
                    state_d = SHIFT;
                end else if (input_en) begin
                    l_d = NW'(l_q + 1'b1);
                end
            end
            SHIFT: state_d = START;
            START: begin
                if (!skip_wait) begin
                    state_d = WAIT;
                end else if (k_q < k_last) begin
                    k_d     = KW'(k_q + 1'b1);
                    state_d = SHIFT;
                end else begin
                    state_d = DRAIN;
                end
            end
            WAIT: begin
                if (pe_value_ready) begin
                    if (k_q < k_last) begin
                        k_d     = KW'(k_q + 1'b1);
                        state_d = SHIFT;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (&(col_done_q | acc_end_flags)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d     = IDLE;
            l_d         = '0;
            k_d         = '0;
            col_done_d  = '0;
            add_start_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            n_q         <= '0;
            l_q         <= '0;
            k_q         <= '0;
            col_done_q  <= '0;
            add_start_q <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            l_q         <= l_d;
            k_q         <= k_d;
            col_done_q  <= col_done_d;
            add_start_q <= add_start_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        in_fifo_shift = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            in_fifo_shift[r] = (state_q == START) && mask[r*COLS];
        end
    end

    assign fifo_has_space = (state_q == LOAD) && (l_q < n_q);
    assign pe_shift       = (state_q == SHIFT) ? mask : '0;
    assign pe_start       = (state_q == START) ? start_mask : '0;
    assign add_start      = add_start_q;
    assign ps_fifo_shift  = add_value_ready;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign drained        = !((state_q == SHIFT) || (state_q == START) || (state_q == WAIT))
                            || (mask == '0);

endmodule

// File: tb/tb_sysarr_wavefront_ctrl.sv
// Directed self-checking bench for sysarr_wavefront_ctrl at ROWS=COLS=4, DEPTH=8.
module tb_sysarr_wavefront_ctrl;

    logic        clk = 1'b0;
    logic        nRST;
    logic        start, abort, input_en, pe_value_ready;
    logic [3:0]  num_inputs;
    logic        fifo_has_space;
    logic [15:0] pe_shift, pe_start;
    logic [3:0]  in_fifo_shift;
    logic [3:0]  acc_end_flags, add_value_ready, add_start, ps_fifo_shift;
    logic        busy, drained, done;
`ifdef SYSARR_ZERO_SKIP_EN
    logic [3:0]  row_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sysarr_wavefront_ctrl #(.ROWS(4), .COLS(4), .DEPTH(8)) dut (
        .clk             (clk),
        .nRST            (nRST),
        .start           (start),
        .abort           (abort),
        .num_inputs      (num_inputs),
        .input_en        (input_en),
        .fifo_has_space  (fifo_has_space),
        .pe_shift        (pe_shift),
        .pe_start        (pe_start),
        .pe_value_ready  (pe_value_ready),
        .in_fifo_shift   (in_fifo_shift),
`ifdef SYSARR_ZERO_SKIP_EN
        .row_zero        (row_zero),
`endif
        .acc_end_flags   (acc_end_flags),
        .add_value_ready (add_value_ready),
        .add_start       (add_start),
        .ps_fifo_shift   (ps_fifo_shift),
        .busy            (busy),
        .drained         (drained),
        .done            (done)
    );

    // Reference wavefront: PE (r,c) live when 0 <= k-(r+c) < n.
    function automatic logic [15:0] exp_mask(input int k, input int n);
        logic [15:0] m;
        int d;
        m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                d = k - (r + c);
                if (d >= 0 && d < n) m[r*4+c] = 1'b1;
            end
        return m;
    endfunction

    function automatic logic [3:0] exp_fifo(input logic [15:0] m);
        return {m[12], m[8], m[4], m[0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        num_inputs = 4'(n);
        cyc();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; start = 0; abort = 0; input_en = 0; pe_value_ready = 0;
        num_inputs = '0; acc_end_flags = 4'hF; add_value_ready = '0;
`ifdef SYSARR_ZERO_SKIP_EN
        row_zero = '0;
`endif
        #22;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || drained !== 1'b1) begin
            errors++; $display("FAIL reset_status got busy=%b done=%b drained=%b want 0 0 1", busy, done, drained);
        end
        checks++;
        if (pe_shift !== 16'h0 || pe_start !== 16'h0 || in_fifo_shift !== 4'h0 || add_start !== 4'h0 || fifo_has_space !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got %h %h %h %h %b want all 0", pe_shift, pe_start, in_fifo_shift, add_start, fifo_has_space);
        end
        acc_end_flags = '0;
        @(negedge clk);
        nRST = 1'b1;
        cyc();
    endtask

    task automatic test_back_to_back();
        acc_end_flags = 4'b0100;
        cyc();
        checks++;
        if (add_start !== 4'b0100) begin errors++; $display("FAIL b2b_first got %b want 0100", add_start); end
        cyc();
        checks++;
        if (add_start !== 4'b0100) begin errors++; $display("FAIL b2b_second got %b want 0100", add_start); end
        acc_end_flags = 4'b0001;
        cyc();
        checks++;
        if (add_start !== 4'b0001) begin errors++; $display("FAIL b2b_switch got %b want 0001", add_start); end
        acc_end_flags = 4'b0000;
        cyc();
        checks++;
        if (add_start !== 4'b0000) begin errors++; $display("FAIL b2b_clear got %b want 0000", add_start); end
    endtask

    // Full load and stepping of one pass; leaves the DUT in DRAIN.
    task automatic test_pass(input int n, input int dly);
        logic [15:0] m;
        int kl;
        kl = n + 4 + 4 - 3;
        do_start(n);
        checks++;
        if (busy !== 1'b1 || fifo_has_space !== 1'b1) begin
            errors++; $display("FAIL pass_load_entry n=%0d got busy=%b space=%b want 1 1", n, busy, fifo_has_space);
        end
        for (int i = 0; i < n; i++) begin
            input_en = 1'b1;
            cyc();
        end
        input_en = 1'b0;
        checks++;
        if (fifo_has_space !== 1'b0 || pe_shift !== 16'h0) begin
            errors++; $display("FAIL pass_loaded n=%0d got space=%b shift=%h want 0 0", n, fifo_has_space, pe_shift);
        end
        cyc();
        for (int k = 0; k <= kl; k++) begin
            m = exp_mask(k, n);
            pe_value_ready = (dly == 1);
            checks++;
            if (pe_shift !== m || pe_start !== 16'h0 || drained !== 1'b0) begin
                errors++; $display("FAIL shift n=%0d k=%0d got %h/%h/%b want %h/0000/0", n, k, pe_shift, pe_start, drained, m);
            end
            cyc();
            checks++;
            if (pe_start !== m || in_fifo_shift !== exp_fifo(m) || pe_shift !== 16'h0) begin
                errors++; $display("FAIL start n=%0d k=%0d got %h/%b want %h/%b", n, k, pe_start, in_fifo_shift, m, exp_fifo(m));
            end
            if (n == 1 && k == 0) begin
                checks++;
                if (pe_start !== 16'h0001 || in_fifo_shift !== 4'b0001) begin
                    errors++; $display("FAIL n1_k0 got %h/%b want 0001/0001", pe_start, in_fifo_shift);
                end
            end
            if (n == 1 && k == 6) begin
                checks++;
                if (pe_start !== 16'h8000 || in_fifo_shift !== 4'b0000) begin
                    errors++; $display("FAIL n1_k6 got %h/%b want 8000/0000", pe_start, in_fifo_shift);
                end
            end
            if (n == 3 && k == 2) begin
                checks++;
                if (pe_start !== 16'h0137) begin errors++; $display("FAIL n3_k2 got %h want 0137", pe_start); end
            end
            if (n == 3 && k == 8) begin
                checks++;
                if (pe_start !== 16'h8000) begin errors++; $display("FAIL n3_k8 got %h want 8000", pe_start); end
            end
            cyc();
            checks++;
            if (pe_start !== 16'h0 || pe_shift !== 16'h0 || busy !== 1'b1) begin
                errors++; $display("FAIL wait n=%0d k=%0d got %h/%h/%b want 0/0/1", n, k, pe_start, pe_shift, busy);
            end
            for (int j = 1; j < dly; j++) begin
                pe_value_ready = 1'b0;
                cyc();
            end
            pe_value_ready = 1'b1;
            cyc();
            pe_value_ready = 1'b0;
        end
        checks++;
        if (pe_shift !== 16'h0 || busy !== 1'b1 || drained !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL drain_entry n=%0d got shift=%h busy=%b drained=%b done=%b want 0 1 1 0", n, pe_shift, busy, drained, done);
        end
    endtask

    task automatic test_drain();
        add_value_ready = 4'b1010;
        #1;
        checks++;
        if (ps_fifo_shift !== 4'b1010) begin errors++; $display("FAIL ps_fifo got %b want 1010", ps_fifo_shift); end
        add_value_ready = '0;
        acc_end_flags = 4'b0011;
        cyc();
        acc_end_flags = 4'b0000;
        checks++;
        if (add_start !== 4'b0011 || done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL drain_flag1 got add=%b done=%b busy=%b want 0011 0 1", add_start, done, busy);
        end
        cyc();
        checks++;
        if (add_start !== 4'b0000 || done !== 1'b0) begin
            errors++; $display("FAIL drain_gap got add=%b done=%b want 0000 0", add_start, done);
        end
        acc_end_flags = 4'b1100;
        cyc();
        acc_end_flags = 4'b0000;
        checks++;
        if (add_start !== 4'b1100 || done !== 1'b1) begin
            errors++; $display("FAIL drain_flag2 got add=%b done=%b want 1100 1", add_start, done);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || add_start !== 4'b0000) begin
            errors++; $display("FAIL drain_idle got done=%b busy=%b add=%b want 0 0 0000", done, busy, add_start);
        end
    endtask

    task automatic test_abort();
        do_start(2);
        input_en = 1'b1;
        cyc(); cyc();
        input_en = 1'b0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            cyc(); cyc();
            pe_value_ready = 1'b1;
            cyc();
            pe_value_ready = 1'b0;
        end
        checks++;
        if (pe_shift !== exp_mask(4, 2)) begin errors++; $display("FAIL abort_k4 got %h want %h", pe_shift, exp_mask(4, 2)); end
        cyc(); cyc();
        abort = 1'b1;
        acc_end_flags = 4'b0001;
        cyc();
        abort = 1'b0;
        acc_end_flags = 4'b0000;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || add_start !== 4'h0 || pe_shift !== 16'h0 || pe_start !== 16'h0 || in_fifo_shift !== 4'h0 || drained !== 1'b1) begin
            errors++; $display("FAIL abort_idle got busy=%b done=%b add=%b shift=%h start=%h want idle, no strobes", busy, done, add_start, pe_shift, pe_start);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_nodone got done=%b busy=%b want 0 0", done, busy); end
        do_start(1);
        checks++;
        if (busy !== 1'b1 || fifo_has_space !== 1'b1) begin
            errors++; $display("FAIL abort_restart got busy=%b space=%b want 1 1", busy, fifo_has_space);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic test_zero_clamp();
        int loaded;
        do_start(0);
        checks++;
        if (done !== 1'b1 || fifo_has_space !== 1'b0 || pe_start !== 16'h0 || pe_shift !== 16'h0) begin
            errors++; $display("FAIL n0_done got done=%b space=%b start=%h shift=%h want 1 0 0 0", done, fifo_has_space, pe_start, pe_shift);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL n0_idle got done=%b busy=%b want 0 0", done, busy); end
        do_start(15);
        do_start(1);
        loaded = 0;
        input_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (fifo_has_space === 1'b1) loaded++;
            cyc();
        end
        input_en = 1'b0;
        checks++;
        if (loaded != 8) begin errors++; $display("FAIL clamp got %0d loads want 8", loaded); end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic test_reset_midpass();
        do_start(1);
        input_en = 1'b1;
        cyc();
        input_en = 1'b0;
        cyc();
        checks++;
        if (pe_shift !== 16'h0001) begin errors++; $display("FAIL midpass_shift got %h want 0001", pe_shift); end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pe_shift !== 16'h0 || drained !== 1'b1) begin
            errors++; $display("FAIL midpass_reset got busy=%b shift=%h drained=%b want 0 0 1", busy, pe_shift, drained);
        end
        @(negedge clk);
        nRST = 1'b1;
        cyc(); cyc();
        checks++;
        if (busy !== 1'b0 || fifo_has_space !== 1'b0 || pe_start !== 16'h0) begin
            errors++; $display("FAIL midpass_discard got busy=%b space=%b start=%h want 0 0 0", busy, fifo_has_space, pe_start);
        end
    endtask

`ifdef SYSARR_ZERO_SKIP_EN
    task automatic test_zero_skip();
        do_start(1);
        input_en = 1'b1;
        cyc();
        input_en = 1'b0;
        cyc();
        row_zero = 4'b1111;
        cyc();
        checks++;
        if (pe_start !== 16'h0 || in_fifo_shift !== 4'b0001) begin
            errors++; $display("FAIL zskip_start got %h/%b want 0000/0001", pe_start, in_fifo_shift);
        end
        cyc();
        row_zero = 4'b0000;
        checks++;
        if (pe_shift !== 16'h0012) begin errors++; $display("FAIL zskip_nowait got %h want 0012", pe_shift); end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_pass(1, 1);
        test_drain();
        test_pass(3, 2);
        test_drain();
        test_abort();
        test_zero_clamp();
        test_reset_midpass();
`ifdef SYSARR_ZERO_SKIP_EN
        test_zero_skip();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
